// File: rtl/vtd.sv
// Video timing detector: recovers active-area pixel coordinates from raw
// hsync/vsync/DE, measures line and frame geometry, and reports lock once the
// measured geometry matches the expected resolution for enough frames.
module vtd #(
  parameter int COUNTER_WIDTH = 10,
  parameter int ACTIVE_X      = 320,
  parameter int ACTIVE_Y      = 240,
  parameter int LOCK_FRAMES   = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_hsync,
  input  logic                     i_vsync,
  input  logic                     i_active,
  output logic                     o_valid,
  output logic [COUNTER_WIDTH-1:0] o_counterX,
  output logic [COUNTER_WIDTH-1:0] o_counterY,
  output logic [COUNTER_WIDTH-1:0] o_width,
  output logic [COUNTER_WIDTH-1:0] o_height,
  output logic [COUNTER_WIDTH-1:0] o_htotal,
  output logic [COUNTER_WIDTH-1:0] o_vtotal,
  output logic                     o_sof,
  output logic                     o_locked,
  output logic                     o_err
);

  localparam int CW = COUNTER_WIDTH;
  localparam int GW = (LOCK_FRAMES > 1) ? $clog2(LOCK_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] EXP_X   = CW'(ACTIVE_X);
  localparam logic [CW-1:0] EXP_Y   = CW'(ACTIVE_Y);
  localparam logic [GW-1:0] LAST_GOOD = GW'(LOCK_FRAMES - 1);

  typedef enum logic [1:0] {
    SEEK    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic [GW-1:0] good_cnt_reg, good_cnt_next;
  logic          err_next;

  logic          hs_q, vs_q, act_q;
  logic [CW-1:0] x_cnt, y_cnt, h_clk_cnt, v_line_cnt;
  logic          err_flag;

  logic          hs_rise, vs_rise, act_fall;
  logic [CW-1:0] y_closed;
  logic          line_bad, frame_good;

  // Counters hold at all-ones rather than wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  assign hs_rise  = i_hsync & ~hs_q;
  assign vs_rise  = i_vsync & ~vs_q;
  assign act_fall = ~i_active & act_q;

  // A line closing on the same clock as vsync rises is folded into the frame
  // before it is judged, so its height and width both count.
  assign y_closed   = act_fall ? sat_inc(y_cnt) : y_cnt;
  assign line_bad   = act_fall && (x_cnt != EXP_X);
  assign frame_good = !err_flag && !line_bad && (y_closed == EXP_Y) &&
                      (y_closed != CNT_MAX) && (x_cnt != CNT_MAX);

  // Lock state and good-frame count; only vsync rising edges move them.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg    <= SEEK;
      good_cnt_reg <= '0;
      o_locked     <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      state_reg    <= state_next;
      good_cnt_reg <= good_cnt_next;
      o_locked     <= (state_next == LOCKED);
      o_err        <= err_next;
    end
  end

  // Next-state logic; the first edge after reset only starts measuring.
  always_comb begin
    state_next    = state_reg;
    good_cnt_next = good_cnt_reg;
    err_next      = 1'b0;
    if (vs_rise) begin
      case (state_reg)
        SEEK: begin
          state_next    = MEASURE;
          good_cnt_next = '0;
        end
        MEASURE: begin
          if (frame_good) begin
            if (good_cnt_reg == LAST_GOOD) begin
              state_next    = LOCKED;
              good_cnt_next = '0;
            end else begin
              good_cnt_next = good_cnt_reg + 1'b1;
            end
          end else begin
            good_cnt_next = '0;
            err_next      = 1'b1;
          end
        end
        LOCKED: begin
          if (!frame_good) begin
            state_next    = MEASURE;
            good_cnt_next = '0;
            err_next      = 1'b1;
          end
        end
        default: begin
          state_next    = SEEK;
          good_cnt_next = '0;
        end
      endcase
    end
  end

  // Edge history, pixel coordinates and geometry measurements.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hs_q       <= 1'b0;
      vs_q       <= 1'b0;
      act_q      <= 1'b0;
      x_cnt      <= '0;
      y_cnt      <= '0;
      h_clk_cnt  <= '0;
      v_line_cnt <= '0;
      err_flag   <= 1'b0;
      o_valid    <= 1'b0;
      o_counterX <= '0;
      o_counterY <= '0;
      o_width    <= '0;
      o_height   <= '0;
      o_htotal   <= '0;
      o_vtotal   <= '0;
      o_sof      <= 1'b0;
    end else begin
      hs_q    <= i_hsync;
      vs_q    <= i_vsync;
      act_q   <= i_active;
      o_valid <= i_active;
      o_sof   <= 1'b0;

      if (i_active) begin
        o_counterX <= x_cnt;
        o_counterY <= y_cnt;
        o_sof      <= (x_cnt == '0) && (y_cnt == '0);
      end

      if (vs_rise || act_fall) begin
        x_cnt <= '0;
      end else if (i_active) begin
        x_cnt <= sat_inc(x_cnt);
      end

      if (act_fall) begin
        o_width <= x_cnt;
      end

      if (vs_rise) begin
        y_cnt <= '0;
      end else if (act_fall) begin
        y_cnt <= sat_inc(y_cnt);
      end

      if (vs_rise) begin
        err_flag <= 1'b0;
      end else if (line_bad) begin
        err_flag <= 1'b1;
      end

      if (hs_rise) begin
        o_htotal  <= h_clk_cnt;
        h_clk_cnt <= CW'(1);
      end else begin
        h_clk_cnt <= sat_inc(h_clk_cnt);
      end

      if (vs_rise) begin
        v_line_cnt <= '0;
        o_height   <= y_closed;
        o_vtotal   <= v_line_cnt;
      end else if (hs_rise) begin
        v_line_cnt <= sat_inc(v_line_cnt);
      end
    end
  end

endmodule

// File: tb/tb_vtd.sv
// Directed bench for vtd on a scaled-down raster (12x6 active in 20x10 total,
// 6-bit counters) so that several frames and counter saturation stay short.
module tb_vtd;

  localparam int CW          = 6;
  localparam int AX          = 12;
  localparam int AY          = 6;
  localparam int LF          = 2;
  localparam int LINE_LEN    = 20;
  localparam int FRAME_LINES = 10;
  localparam int VS_LINE     = 7;
  localparam int CMAX        = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_hsync = 1'b0;
  logic          i_vsync = 1'b0;
  logic          i_active = 1'b0;
  logic          o_valid;
  logic [CW-1:0] o_counterX, o_counterY, o_width, o_height, o_htotal, o_vtotal;
  logic          o_sof, o_locked, o_err;

  int errors = 0;
  int checks = 0;
  int exp_lock = 0;

  always #5 clk = ~clk;

  vtd #(
    .COUNTER_WIDTH(CW),
    .ACTIVE_X     (AX),
    .ACTIVE_Y     (AY),
    .LOCK_FRAMES  (LF)
  ) dut (
    .i_clk     (clk),
    .i_rst     (i_rst),
    .i_hsync   (i_hsync),
    .i_vsync   (i_vsync),
    .i_active  (i_active),
    .o_valid   (o_valid),
    .o_counterX(o_counterX),
    .o_counterY(o_counterY),
    .o_width   (o_width),
    .o_height  (o_height),
    .o_htotal  (o_htotal),
    .o_vtotal  (o_vtotal),
    .o_sof     (o_sof),
    .o_locked  (o_locked),
    .o_err     (o_err)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"},  int'(o_valid), 0);
    check({tag, "_x"},      int'(o_counterX), 0);
    check({tag, "_y"},      int'(o_counterY), 0);
    check({tag, "_width"},  int'(o_width), 0);
    check({tag, "_height"}, int'(o_height), 0);
    check({tag, "_htotal"}, int'(o_htotal), 0);
    check({tag, "_vtotal"}, int'(o_vtotal), 0);
    check({tag, "_sof"},    int'(o_sof), 0);
    check({tag, "_locked"}, int'(o_locked), 0);
    check({tag, "_err"},    int'(o_err), 0);
  endtask

  // One frame: lines below act_lines carry AX active pixels (odd_line carries
  // odd_len instead); an optional one-clock reset lands at (rst_line, rst_col).
  task automatic run_frame(input int fnum, input int act_lines, input int odd_line,
                           input int odd_len, input int rst_line, input int rst_col,
                           input int exp_err, input int exp_lock_after,
                           input int exp_height, input int exp_vtotal);
    bit pix_ok;
    pix_ok = 1'b1;
    for (int line = 0; line < FRAME_LINES; line++) begin
      int act_len;
      int len;
      act_len = (line < act_lines) ? ((line == odd_line) ? odd_len : AX) : 0;
      len     = (act_len + 8 > LINE_LEN) ? act_len + 8 : LINE_LEN;
      for (int col = 0; col < len; col++) begin
        i_active = (col < act_len);
        i_hsync  = (col >= len - 6) && (col < len - 4);
        i_vsync  = (line == VS_LINE && col >= len - 4) || (line == VS_LINE + 1) ||
                   (line == VS_LINE + 2 && col < len - 4);
        i_rst    = (line == rst_line) && (col == rst_col);
        @(posedge clk);
        #1;
        if (i_rst) begin
          check_all_zero("midrst");
          pix_ok   = 1'b0;
          exp_lock = 0;
        end else begin
          if (pix_ok) begin
            check("valid", int'(o_valid), int'(i_active));
            check("sof", int'(o_sof), int'(i_active && col == 0 && line == 0));
            if (i_active) begin
              check("cx", int'(o_counterX), (col > CMAX) ? CMAX : col);
              check("cy", int'(o_counterY), line);
            end
            if (act_len > 0 && col == act_len)
              check("width", int'(o_width), (act_len > CMAX) ? CMAX : act_len);
          end
          if (line == VS_LINE && col == len - 4) begin
            exp_lock = exp_lock_after;
            check("frame_err", int'(o_err), exp_err);
            check("height", int'(o_height), exp_height);
            check("vtotal", int'(o_vtotal), exp_vtotal);
            check("htotal", int'(o_htotal), LINE_LEN);
            $display("frame %0d: err=%0d locked=%0d width=%0d height=%0d htotal=%0d vtotal=%0d",
                     fnum, o_err, o_locked, o_width, o_height, o_htotal, o_vtotal);
          end else begin
            check("err_idle", int'(o_err), 0);
          end
          check("locked", int'(o_locked), exp_lock);
        end
      end
    end
  endtask

  initial begin
    i_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    i_rst = 1'b0;

    // Lock acquisition from reset: the first vsync only starts measuring.
    run_frame(0,  AY, -1, 0, -1, -1, 0, 0, AY, 8);
    run_frame(1,  AY, -1, 0, -1, -1, 0, 0, AY, FRAME_LINES);
    run_frame(2,  AY, -1, 0, -1, -1, 0, 1, AY, FRAME_LINES);
    // One short line breaks lock; two clean frames restore it.
    run_frame(3,  AY,  2, AX - 1, -1, -1, 1, 0, AY, FRAME_LINES);
    run_frame(4,  AY, -1, 0, -1, -1, 0, 0, AY, FRAME_LINES);
    run_frame(5,  AY, -1, 0, -1, -1, 0, 1, AY, FRAME_LINES);
    // One active line missing.
    run_frame(6,  AY - 1, -1, 0, -1, -1, 1, 0, AY - 1, FRAME_LINES);
    run_frame(7,  AY, -1, 0, -1, -1, 0, 0, AY, FRAME_LINES);
    run_frame(8,  AY, -1, 0, -1, -1, 0, 1, AY, FRAME_LINES);
    // Overlong line drives x to saturation.
    run_frame(9,  AY,  0, 70, -1, -1, 1, 0, AY, FRAME_LINES);
    run_frame(10, AY, -1, 0, -1, -1, 0, 0, AY, FRAME_LINES);
    run_frame(11, AY, -1, 0, -1, -1, 0, 1, AY, FRAME_LINES);
    // Reset mid-line while locked: remaining partial frame is not judged.
    run_frame(12, AY, -1, 0, 2, 5, 0, 0, 4, 6);
    run_frame(13, AY, -1, 0, -1, -1, 0, 0, AY, FRAME_LINES);
    run_frame(14, AY, -1, 0, -1, -1, 0, 1, AY, FRAME_LINES);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
